// File: rtl/wb_rr_interconnect.sv
// wb_rr_interconnect
//   Wishbone B3 shared-bus interconnect: MASTERS initiators share one bus to
//   SLAVES targets. One master owns the bus at a time (registered round-robin
//   grant, never preempted while its cyc stays high). The owner's address is
//   decoded against per-slave base/mask pairs (lowest matching index wins).
//   A decode miss returns a one-cycle error. A watchdog aborts a strobed
//   transfer that waits TIMEOUT cycles for a response.
//
// Optional feature (macro WB_RR_PRIORITY_EN):
//   Adds input m_prio_i. Requesters with priority set are scanned first, in
//   round-robin order. Grants are still never preempted. Without the macro,
//   arbitration is pure round-robin.
//
// Ports (all buses flat, LSB-first by port number):
//   clk_i, rst_i             clock, synchronous active-high reset
//   m_*_i / m_*_o            master-side Wishbone signals (MASTERS ports)
//   s_*_o / s_*_i            slave-side Wishbone signals (SLAVES ports)
//   bus_busy_o               registered "a grant is held"
module wb_rr_interconnect #(
    parameter int                    MASTERS = 2,
    parameter int                    SLAVES  = 2,
    parameter int                    DW      = 32,
    parameter int                    AW      = 32,
    parameter logic [AW*SLAVES-1:0]  S_BASE  = '0,
    parameter logic [AW*SLAVES-1:0]  S_MASK  = '0,
    parameter int                    TIMEOUT = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [AW*MASTERS-1:0]    m_adr_i,
    input  logic [DW*MASTERS-1:0]    m_dat_i,
    input  logic [DW/8*MASTERS-1:0]  m_sel_i,
    input  logic [MASTERS-1:0]       m_we_i,
    input  logic [MASTERS-1:0]       m_cyc_i,
    input  logic [MASTERS-1:0]       m_stb_i,
    input  logic [3*MASTERS-1:0]     m_cti_i,
    input  logic [2*MASTERS-1:0]     m_bte_i,
    output logic [DW*MASTERS-1:0]    m_dat_o,
    output logic [MASTERS-1:0]       m_ack_o,
    output logic [MASTERS-1:0]       m_err_o,
    output logic [MASTERS-1:0]       m_rty_o,
    output logic [AW*SLAVES-1:0]     s_adr_o,
    output logic [DW*SLAVES-1:0]     s_dat_o,
    output logic [DW/8*SLAVES-1:0]   s_sel_o,
    output logic [SLAVES-1:0]        s_we_o,
    output logic [SLAVES-1:0]        s_cyc_o,
    output logic [SLAVES-1:0]        s_stb_o,
    output logic [3*SLAVES-1:0]      s_cti_o,
    output logic [2*SLAVES-1:0]      s_bte_o,
    input  logic [DW*SLAVES-1:0]     s_dat_i,
    input  logic [SLAVES-1:0]        s_ack_i,
    input  logic [SLAVES-1:0]        s_err_i,
    input  logic [SLAVES-1:0]        s_rty_i,
    output logic                     bus_busy_o
`ifdef WB_RR_PRIORITY_EN
    ,
    input  logic [MASTERS-1:0]       m_prio_i
`endif
);

    localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int BW = DW / 8;

    // Arbiter state: own_q = OWNED(gnt_q), !own_q = IDLE
    logic          own_q, own_d;
    logic [MW-1:0] gnt_q, gnt_d;
    logic [MW-1:0] ptr_q, ptr_d;
    logic [TW-1:0] wdt_q, wdt_d;
    logic          err_q, err_d;

    // Owner's request, selected by the registered grant
    logic [AW-1:0] o_adr;
    logic [DW-1:0] o_dat;
    logic [BW-1:0] o_sel;
    logic [2:0]    o_cti;
    logic [1:0]    o_bte;
    logic          o_we, o_cyc, o_stb;

    logic          rel, arb;
    logic [MASTERS-1:0] req_hi;
    logic          found_hi, found_any;
    logic [MW-1:0] pick_hi, pick_any, nxt;
    logic          hit;
    logic [SW-1:0] sel;
    logic          r_ack, r_err, r_rty, rsp;
    logic          active, waiting, tmo;

    always_comb begin
        o_adr = m_adr_i[int'(gnt_q)*AW +: AW];
        o_dat = m_dat_i[int'(gnt_q)*DW +: DW];
        o_sel = m_sel_i[int'(gnt_q)*BW +: BW];
        o_cti = m_cti_i[int'(gnt_q)*3 +: 3];
        o_bte = m_bte_i[int'(gnt_q)*2 +: 2];
        o_we  = m_we_i[gnt_q];
        o_cyc = m_cyc_i[gnt_q];
        o_stb = m_stb_i[gnt_q];
    end

    // Arbitration: re-arbitrate when idle or when the owner drops cyc.
    // On release the pointer moves past the old owner and the scan starts
    // there in the same edge, so handover costs no idle cycle.
    always_comb begin
        int idx;
        idx = 0;
        rel = own_q && !o_cyc;
        arb = !own_q || rel;
        nxt = (int'(gnt_q) == MASTERS - 1) ? '0 : gnt_q + 1'b1;
        ptr_d = rel ? nxt : ptr_q;
`ifdef WB_RR_PRIORITY_EN
        req_hi = m_cyc_i & m_prio_i;
`else
        req_hi = '0;
`endif
        found_hi  = 1'b0;
        found_any = 1'b0;
        pick_hi   = '0;
        pick_any  = '0;
        for (int i = 0; i < MASTERS; i++) begin
            idx = (int'(ptr_d) + i) % MASTERS;
            if (req_hi[idx] && !found_hi) begin
                found_hi = 1'b1;
                pick_hi  = MW'(idx);
            end
            if (m_cyc_i[idx] && !found_any) begin
                found_any = 1'b1;
                pick_any  = MW'(idx);
            end
        end
        own_d = own_q;
        gnt_d = gnt_q;
        if (arb) begin
            own_d = found_any;
            gnt_d = found_hi ? pick_hi : pick_any;
        end
    end

    // Address decode; scanning downward leaves the lowest match in sel
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int s = SLAVES - 1; s >= 0; s--) begin
            if ((o_adr & S_MASK[s*AW +: AW]) == (S_BASE[s*AW +: AW] & S_MASK[s*AW +: AW])) begin
                hit = 1'b1;
                sel = SW'(s);
            end
        end
    end

    // Response handling, decode-miss error and watchdog
    always_comb begin
        r_ack   = s_ack_i[sel];
        r_err   = s_err_i[sel];
        r_rty   = s_rty_i[sel];
        rsp     = r_ack || r_err || r_rty;
        active  = own_q && o_cyc && o_stb;
        waiting = active && hit && !rsp;
        // A response in the timeout cycle makes waiting false, so it wins
        tmo     = (TIMEOUT != 0) && waiting && (wdt_q == TW'(TIMEOUT - 1));
        // err_q suppresses a back-to-back repeat of the miss error
        err_d   = active && !hit && !err_q;
        if (arb || rsp || tmo || TIMEOUT == 0)
            wdt_d = '0;
        else if (waiting)
            wdt_d = wdt_q + 1'b1;
        else
            wdt_d = wdt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            own_q <= 1'b0;
            gnt_q <= '0;
            ptr_q <= '0;
            wdt_q <= '0;
            err_q <= 1'b0;
        end else begin
            own_q <= own_d;
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
            wdt_q <= wdt_d;
            err_q <= err_d;
        end
    end

    // Slave side: broadcast owner fields, cyc/stb only to the decoded slave
    always_comb begin
        s_adr_o = {SLAVES{o_adr}};
        s_dat_o = {SLAVES{o_dat}};
        s_sel_o = {SLAVES{o_sel}};
        s_we_o  = {SLAVES{o_we}};
        s_cti_o = {SLAVES{o_cti}};
        s_bte_o = {SLAVES{o_bte}};
        s_cyc_o = '0;
        s_stb_o = '0;
        if (own_q && hit) begin
            s_cyc_o[sel] = o_cyc;
            s_stb_o[sel] = o_cyc && o_stb && !tmo;
        end
    end

    // Master side: only the owner sees data and responses
    always_comb begin
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (own_q) begin
            if (hit) begin
                m_dat_o[int'(gnt_q)*DW +: DW] = s_dat_i[int'(sel)*DW +: DW];
                m_ack_o[gnt_q] = r_ack;
                m_rty_o[gnt_q] = r_rty;
            end
            m_err_o[gnt_q] = (hit && r_err) || err_q || tmo;
        end
    end

    assign bus_busy_o = own_q;

endmodule

// File: tb/tb_wb_rr_interconnect.sv
// Directed bench for wb_rr_interconnect: 2 masters, 2 slaves
// (slave 0 at 0x0xxx_xxxx, slave 1 at 0x1xxx_xxxx), TIMEOUT = 4.
module tb_wb_rr_interconnect;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] m_adr, m_dat;
    logic [7:0]  m_sel;
    logic [1:0]  m_we, m_cyc, m_stb;
    logic [5:0]  m_cti;
    logic [3:0]  m_bte;
    logic [63:0] m_dat_o;
    logic [1:0]  m_ack_o, m_err_o, m_rty_o;
    logic [63:0] s_adr_o, s_dat_o;
    logic [7:0]  s_sel_o;
    logic [1:0]  s_we_o, s_cyc_o, s_stb_o;
    logic [5:0]  s_cti_o;
    logic [3:0]  s_bte_o;
    logic [63:0] s_dat_i;
    logic [1:0]  s_ack_i, s_err_i, s_rty_i;
    logic        bus_busy;
`ifdef WB_RR_PRIORITY_EN
    logic [1:0]  m_prio;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_rr_interconnect #(
        .MASTERS(2), .SLAVES(2), .DW(32), .AW(32),
        .S_BASE(64'h1000_0000_0000_0000),
        .S_MASK(64'hF000_0000_F000_0000),
        .TIMEOUT(4)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .bus_busy_o(bus_busy)
`ifdef WB_RR_PRIORITY_EN
        , .m_prio_i(m_prio)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        m_cti = '0; m_bte = '0; s_dat_i = '0; s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
`ifdef WB_RR_PRIORITY_EN
        m_prio = '0;
`endif
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({bus_busy, s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o} !== 11'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0", {bus_busy, s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o});
        end
        checks++;
        if (m_dat_o !== 64'h0) begin
            errors++;
            $display("FAIL reset_mdat got %h exp 0", m_dat_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        m_adr[31:0] = 32'h0000_0010; m_sel = 8'h0F; m_cyc = 2'b01; m_stb = 2'b01;
        #1;
        checks++;
        if ({bus_busy, s_cyc_o} !== 3'b000) begin
            errors++;
            $display("FAIL rd_pre_grant got %b exp 000", {bus_busy, s_cyc_o});
        end
        step();
        checks++;
        if ({bus_busy, s_cyc_o, s_stb_o} !== 5'b1_01_01) begin
            errors++;
            $display("FAIL rd_grant got %b exp 10101", {bus_busy, s_cyc_o, s_stb_o});
        end
        checks++;
        if ({s_adr_o, s_sel_o} !== {64'h0000_0010_0000_0010, 8'hFF}) begin
            errors++;
            $display("FAIL rd_bcast got %h exp 000000100000001_0ff", {s_adr_o, s_sel_o});
        end
        step();
        step();
        s_dat_i = 64'h0000_0000_DEAD_BEEF; s_ack_i = 2'b01;
        #1;
        checks++;
        if ({m_ack_o, m_err_o, s_cyc_o} !== 6'b01_00_01) begin
            errors++;
            $display("FAIL rd_ack got %b exp 010001", {m_ack_o, m_err_o, s_cyc_o});
        end
        checks++;
        if (m_dat_o !== 64'h0000_0000_DEAD_BEEF) begin
            errors++;
            $display("FAIL rd_data got %h exp 00000000deadbeef", m_dat_o);
        end
        step();
        idle_inputs();
        step();
        checks++;
        if ({bus_busy, s_cyc_o, m_ack_o} !== 5'b0) begin
            errors++;
            $display("FAIL rd_release got %b exp 00000", {bus_busy, s_cyc_o, m_ack_o});
        end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        m_adr = {32'h1000_0040, 32'h0000_0020}; m_cyc = 2'b11;
        step();
        checks++;
        if ({bus_busy, s_cyc_o} !== 3'b1_01) begin
            errors++;
            $display("FAIL arb_first got %b exp 101", {bus_busy, s_cyc_o});
        end
        m_cyc = 2'b10;
        step();
        checks++;
        if ({bus_busy, s_cyc_o} !== 3'b1_10) begin
            errors++;
            $display("FAIL arb_handover got %b exp 110", {bus_busy, s_cyc_o});
        end
        s_dat_i = {32'hCAFE_F00D, 32'h1111_1111};
        #1;
        checks++;
        if (m_dat_o !== 64'hCAFE_F00D_0000_0000) begin
            errors++;
            $display("FAIL arb_owner_data got %h exp cafef00d00000000", m_dat_o);
        end
        m_cyc = 2'b11;
        step();
        step();
        checks++;
        if (s_cyc_o !== 2'b10) begin
            errors++;
            $display("FAIL arb_no_preempt got %b exp 10", s_cyc_o);
        end
        m_cyc = 2'b01;
        step();
        checks++;
        if ({bus_busy, s_cyc_o} !== 3'b1_01) begin
            errors++;
            $display("FAIL arb_regrant got %b exp 101", {bus_busy, s_cyc_o});
        end
        idle_inputs();
        step();
    endtask

    task automatic test_decode_miss();
        pulse_reset();
        m_adr[31:0] = 32'hFFFF_0000; m_cyc = 2'b01; m_stb = 2'b01;
        step();
        checks++;
        if ({bus_busy, m_err_o, s_cyc_o} !== 5'b1_00_00) begin
            errors++;
            $display("FAIL miss_grant got %b exp 10000", {bus_busy, m_err_o, s_cyc_o});
        end
        step();
        checks++;
        if ({m_err_o, s_cyc_o} !== 4'b01_00) begin
            errors++;
            $display("FAIL miss_err got %b exp 0100", {m_err_o, s_cyc_o});
        end
        step();
        checks++;
        if (m_err_o !== 2'b00) begin
            errors++;
            $display("FAIL miss_one_cycle got %b exp 00", m_err_o);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_timeout();
        logic [5:0] exp;
        pulse_reset();
        m_adr[31:0] = 32'h0000_0100; m_cyc = 2'b01; m_stb = 2'b01;
        step();
        // waiting cycles 1..12: timeout at 4 and 8, ack at 12 beats the timeout
        for (int c = 1; c <= 12; c++) begin
            if (c == 12) s_ack_i = 2'b01;
            #1;
            exp = (c == 4 || c == 8) ? 6'b01_00_00 : ((c == 12) ? 6'b00_01_01 : 6'b00_01_00);
            checks++;
            if ({m_err_o, s_stb_o, m_ack_o} !== exp) begin
                errors++;
                $display("FAIL tmo_cycle%0d got %b exp %b", c, {m_err_o, s_stb_o, m_ack_o}, exp);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        m_adr = {32'h1000_0000, 32'h0000_0000}; m_cyc = 2'b01;
        step();
        m_cyc = 2'b10;
        step();
        m_stb = 2'b10;
        #1;
        checks++;
        if ({bus_busy, s_cyc_o, s_stb_o} !== 5'b1_10_10) begin
            errors++;
            $display("FAIL rstmid_pending got %b exp 11010", {bus_busy, s_cyc_o, s_stb_o});
        end
        rst = 1'b1;
        step();
        checks++;
        if ({bus_busy, s_cyc_o, s_stb_o, m_ack_o, m_err_o} !== 9'b0) begin
            errors++;
            $display("FAIL rstmid_drop got %b exp 0", {bus_busy, s_cyc_o, s_stb_o, m_ack_o, m_err_o});
        end
        rst = 1'b0;
        m_cyc = 2'b11; m_stb = 2'b00;
        step();
        checks++;
        if (s_cyc_o !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_ptr got %b exp 01", s_cyc_o);
        end
        idle_inputs();
        step();
    endtask

`ifdef WB_RR_PRIORITY_EN
    task automatic test_priority();
        pulse_reset();
        m_adr = {32'h1000_0000, 32'h0000_0000}; m_prio = 2'b10; m_cyc = 2'b11;
        step();
        checks++;
        if (s_cyc_o !== 2'b10) begin
            errors++;
            $display("FAIL prio_grant got %b exp 10", s_cyc_o);
        end
        idle_inputs();
        step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL sim_timeout got running exp finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_decode_miss();
        test_timeout();
        test_reset_mid();
`ifdef WB_RR_PRIORITY_EN
        test_priority();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
